sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Two-requester arbiter and sequencer in front of the SDRAM bus core (sdram_addr/read/write/writedata/readdata/finished interface).
Port 0 is the recorder (writes) and port 1 is the player (reads); either port may read or write.
The block round-robins grants, latches the winning command, and holds it on the bus until the core reports completion or a timeout fires.
It then returns a one-cycle done (and error) pulse to the owner.

Parameters:
ADDR_W, 23, SDRAM word address width
DATA_W, 16, data width per transfer
TIMEOUT, 1023, max cycles a command may stay outstanding before abort

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request, level, held until p0_done
p0_we  in  1  port 0 op: 1 = write, 0 = read
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_rdata  out  DATA_W  port 0 read data, valid with p0_done, held until next port 0 read completes
p0_done  out  1  one-cycle completion pulse
p0_err  out  1  one-cycle timeout pulse, coincident with p0_done
p1_req / p1_we / p1_addr / p1_wdata / p1_rdata / p1_done / p1_err  same as port 0
sdram_addr  out  ADDR_W  to bus core
sdram_read  out  1  to bus core, level while read outstanding
sdram_write  out  1  to bus core, level while write outstanding
sdram_writedata  out  DATA_W  to bus core
sdram_readdata  in  DATA_W  from bus core
sdram_finished  in  1  from bus core, one-cycle completion
o_busy  out  1  high in BUSY
o_grant  out  1  index of current/last granted port

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, state IDLE, timeout counter 0, last_grant=1 so port 0 wins the first tie. An outstanding command is abandoned and no done is issued.
- All outputs are registered.
- State IDLE: if any req is high, select the winner. If exactly one requests, that port wins. If both request, the port != last_grant wins.
  - Latch addr, we, wdata and winner; set o_grant = winner; go to BUSY; clear the counter.
  - sdram_read/sdram_write rise on the clock edge after the req sample (1-cycle latency).
- State BUSY: drive the latched addr/wdata and assert exactly one of sdram_read/sdram_write.
  - Req/addr/data changes on the input ports are ignored.
  - Counter increments each cycle.
  - On sdram_finished=1: deassert read/write at the next edge. For reads, capture sdram_readdata into pN_rdata. Pulse pN_done for 1 cycle. Set last_grant=winner. Go to IDLE.
  - Else if counter==TIMEOUT-1: deassert read/write, pulse pN_done and pN_err, set last_grant=winner, go to IDLE. pN_rdata is unchanged.
  - finished and timeout in the same cycle: finished wins, no err.
- Done pulses one cycle after the edge sampling finished. The pulse occurs in the cycle IDLE is entered.
- In IDLE, req from the port just completed is ignored for that first IDLE cycle (the done cycle). This gives the requester one cycle to drop req. This one-cycle bubble also lets the bus core return to its idle state.
- If req is still high the cycle after done, it is a new request.
- sdram_finished in IDLE is ignored.
- Back-to-back with both ports requesting continuously: grants alternate 0,1,0,1. Spacing is ≥ 2 cycles of bus deassertion between commands.
- o_busy = (state==BUSY).

Decomposition:
- Package sdram_arb_pkg:
  - state enum {ARB_IDLE, ARB_BUSY}
  - port index typedef (1 bit)
  - ADDR_W/DATA_W defaults
  - TIMEOUT default constant
- Sub-module rr_arb2: combinational two-way round-robin pick. Inputs req[1:0] and last_grant; outputs valid and winner. Kept separate for a standalone unit test.
- Datapath latches and FSM live in sdram_arbiter.

Test Plan:
- Reset then p0_req=1, we=1, addr=0x000010, wdata=0xBEEF → sdram_write=1 next cycle with addr 0x000010 and data 0xBEEF. finished after 5 cycles → p0_done 1 cycle later, p0_err=0, sdram_write low.
- p1 read at addr 0x7FFFFF, bus core returns 0x1234 with finished → p1_rdata=0x1234 with p1_done. p1_rdata holds 0x1234 while a later p0 write completes.
- Both req held high from reset, 4 transactions → grant order 0,1,0,1. read/write never both high. ≥1 idle cycle between commands.
- TIMEOUT=8, p0 read, finished never asserted → read deasserts and p0_done=p0_err=1 exactly 8 cycles after sdram_read rose. Next grant goes to p1 if it is requesting.
- p0 changes addr/wdata mid-BUSY → sdram_addr/writedata stay at the latched values.
- i_rst_n pulsed low mid-BUSY → sdram_read/write and all done/err drop asynchronously and no done is issued. After release, a pending p0/p1 tie grants p0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and default sizes for the SDRAM two-port arbiter
package sdram_arb_pkg;
  localparam int ADDR_W_DEF  = 23;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 1023;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef logic port_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick
// i_req[1:0] requests, i_last last granted port; o_valid any request, o_winner chosen port
module rr_arb2
  import sdram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_t      i_last,
  output logic       o_valid,
  output port_t      o_winner
);
  assign o_valid  = |i_req;
  assign o_winner = &i_req ? ~i_last : i_req[1];
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-port arbiter and command sequencer for the SDRAM bus core
// pN_*: request ports (req/we/addr/wdata in, rdata/done/err out)
// sdram_*: bus core command interface; o_busy command outstanding; o_grant current/last owner
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [DATA_W-1:0] sdram_writedata,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_finished,
  output logic              o_busy,
  output logic              o_grant
);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t        r_state, w_next;
  port_t             r_last, r_grant, w_winner;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_p0_rdata, r_p1_rdata;
  logic              r_rd, r_wr, r_p0_done, r_p1_done, r_p0_err, r_p1_err;
  logic              w_valid, w_hold, w_go, w_end;
  rr_arb2 u_rr (
    .i_req   ({p1_req, p0_req}),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_winner(w_winner)
  );
  // The done cycle ignores every request: the owner gets time to drop req and
  // the bus sees at least two deasserted cycles between commands.
  assign w_hold = r_p0_done | r_p1_done;
  always_comb begin
    w_go   = (r_state == ARB_IDLE) && w_valid && !w_hold;
    w_end  = (r_state == ARB_BUSY) && (sdram_finished || r_cnt == CW'(TIMEOUT - 1));
    w_next = w_go ? ARB_BUSY : w_end ? ARB_IDLE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= ARB_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
      r_p0_done  <= 1'b0;
      r_p1_done  <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
    end else begin
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      r_p0_err  <= 1'b0;
      r_p1_err  <= 1'b0;
      if (w_go) begin
        r_grant <= w_winner;
        r_addr  <= w_winner ? p1_addr : p0_addr;
        r_wdata <= w_winner ? p1_wdata : p0_wdata;
        r_wr    <= w_winner ? p1_we : p0_we;
        r_rd    <= w_winner ? !p1_we : !p0_we;
        r_cnt   <= '0;
      end else if (w_end) begin
        r_rd      <= 1'b0;
        r_wr      <= 1'b0;
        r_last    <= r_grant;
        r_p0_done <= !r_grant;
        r_p1_done <= r_grant;
        r_p0_err  <= !r_grant && !sdram_finished;
        r_p1_err  <= r_grant && !sdram_finished;
        if (sdram_finished && r_rd && !r_grant) r_p0_rdata <= sdram_readdata;
        if (sdram_finished && r_rd && r_grant) r_p1_rdata <= sdram_readdata;
      end else if (r_state == ARB_BUSY) r_cnt <= r_cnt + CW'(1);
    end
  assign sdram_addr      = r_addr;
  assign sdram_writedata = r_wdata;
  assign sdram_read      = r_rd;
  assign sdram_write     = r_wr;
  assign p0_rdata        = r_p0_rdata;
  assign p1_rdata        = r_p1_rdata;
  assign p0_done         = r_p0_done;
  assign p1_done         = r_p1_done;
  assign p0_err          = r_p0_err;
  assign p1_err          = r_p1_err;
  assign o_busy          = (r_state == ARB_BUSY);
  assign o_grant         = r_grant;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, sdram_finished = 0;
  logic [22:0] p0_addr = 0, p1_addr = 0;
  logic [15:0] p0_wdata = 0, p1_wdata = 0, sdram_readdata = 0;
  logic [15:0] p0_rdata, p1_rdata, sdram_writedata;
  logic [22:0] sdram_addr;
  logic        p0_done, p0_err, p1_done, p1_err, sdram_read, sdram_write, o_busy, o_grant;
  int          errs = 0, n = 0, gap;
  always #5 i_clk = ~i_clk;
  sdram_arbiter #(.ADDR_W(23), .DATA_W(16), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
    .sdram_addr(sdram_addr), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_finished(sdram_finished), .o_busy(o_busy), .o_grant(o_grant)
  );
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_outs", {o_busy, o_grant, sdram_read, sdram_write, p0_done, p0_err, p1_done, p1_err}, 0);
    chk("rst_addr", sdram_addr, 0);
    i_rst_n = 1;
    tick;
    p0_req = 1; p0_we = 1; p0_addr = 23'h000010; p0_wdata = 16'hBEEF;
    tick;
    chk("w_rw", {sdram_read, sdram_write}, 2'b01);
    chk("w_addr", sdram_addr, 23'h000010);
    chk("w_data", sdram_writedata, 16'hBEEF);
    chk("w_busy_grant", {o_busy, o_grant}, 2'b10);
    p0_addr = 23'h000055; p0_wdata = 16'h1111;
    repeat (4) tick;
    chk("hold_addr", sdram_addr, 23'h000010);
    chk("hold_data", sdram_writedata, 16'hBEEF);
    chk("hold_write", sdram_write, 1);
    sdram_finished = 1;
    tick;
    sdram_finished = 0;
    chk("w_done", {p0_done, p0_err, p1_done, sdram_write, o_busy}, 5'b10000);
    p0_req = 0;
    tick;
    chk("w_done_pulse", p0_done, 0);
    p1_req = 1; p1_we = 0; p1_addr = 23'h7FFFFF;
    tick;
    chk("r_rw", {sdram_read, sdram_write, o_grant}, 3'b101);
    chk("r_addr", sdram_addr, 23'h7FFFFF);
    sdram_readdata = 16'h1234; sdram_finished = 1;
    tick;
    sdram_readdata = 16'h0000; sdram_finished = 0;
    chk("r_done", {p1_done, p1_err, p0_done, sdram_read}, 4'b1000);
    chk("r_rdata", p1_rdata, 16'h1234);
    p1_req = 0;
    tick;
    sdram_finished = 1;
    tick;
    sdram_finished = 0;
    chk("idle_fin", {p0_done, p1_done, o_busy}, 0);
    p0_req = 1; p0_we = 1; p0_addr = 23'h000020; p0_wdata = 16'hAAAA;
    tick;
    chk("w2_write", sdram_write, 1);
    sdram_finished = 1;
    tick;
    sdram_finished = 0;
    chk("w2_done", p0_done, 1);
    chk("r_rdata_hold", p1_rdata, 16'h1234);
    chk("w_no_rdata", p0_rdata, 0);
    p0_req = 0;
    tick;
    p0_req = 1; p0_we = 0; p0_addr = 23'h000030;
    tick;
    chk("to_read", {sdram_read, o_grant}, 2'b10);
    p1_req = 1; p1_we = 1; p1_addr = 23'h000040; p1_wdata = 16'h5555;
    repeat (7) tick;
    chk("to_pre", {sdram_read, p0_done, p0_err}, 3'b100);
    tick;
    chk("to_fire", {sdram_read, p0_done, p0_err, o_busy}, 4'b0110);
    chk("to_rdata", p0_rdata, 0);
    p0_req = 0;
    tick;
    chk("to_bubble", {sdram_write, p0_done, p0_err}, 0);
    tick;
    chk("to_next", {sdram_write, o_grant}, 2'b11);
    chk("to_next_addr", sdram_addr, 23'h000040);
    sdram_finished = 1;
    tick;
    sdram_finished = 0;
    chk("to_next_done", {p1_done, p1_err}, 2'b10);
    p1_req = 0;
    tick;
    p1_req = 1; p1_we = 0; p1_addr = 23'h000200;
    tick;
    chk("ar_busy", {sdram_read, o_grant}, 2'b11);
    p0_req = 1; p0_we = 1; p0_addr = 23'h000100; p0_wdata = 16'h0F0F;
    #2 i_rst_n = 0;
    #1;
    chk("ar_drop", {sdram_read, sdram_write, o_busy, o_grant, p0_done, p1_done, p0_err, p1_err}, 0);
    tick;
    tick;
    chk("ar_nodone", {p0_done, p1_done, o_busy}, 0);
    i_rst_n = 1;
    for (int t = 0; t < 4; t++) begin
      gap = 0;
      while (!(sdram_read | sdram_write) && gap < 20) begin
        gap++;
        tick;
      end
      chk("bb_started", sdram_read | sdram_write, 1);
      if (t > 0) chk("bb_gap", gap >= 2, 1);
      chk("bb_grant", o_grant, t % 2);
      chk("bb_op", {sdram_read, sdram_write}, (t % 2) ? 2'b10 : 2'b01);
      tick;
      chk("bb_excl", sdram_read & sdram_write, 0);
      sdram_readdata = 16'hC000 + 16'(t); sdram_finished = 1;
      tick;
      sdram_finished = 0;
      chk("bb_done", {p0_done, p1_done}, (t % 2) ? 2'b01 : 2'b10);
      if (t % 2) chk("bb_rdata", p1_rdata, 16'hC000 + 16'(t));
    end
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
